// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared opcodes, FSM states and decode helpers for the MDU
//
// Purpose : opcode encodings presented by ID/EX to mdu_iter, FSM state
//           encoding, and small decode helpers used by the MDU.
// Ports   : none (package)
package mdu_pkg;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } mdu_state_t;

  // Multi-cycle ops that occupy the iterative datapath.
  function automatic logic op_is_muldiv(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // Any recognised MDU op; unused encodings behave as NOP.
  function automatic logic op_is_valid(input logic [3:0] op);
    return (op != OP_NOP) && (op <= OP_MTLO);
  endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// rtl/mdu_iter_step.sv - one combinational multiply or divide iteration
//
// Purpose : a single shift-add (multiply) or restoring trial-subtract
//           (divide) step on a WIDTH+1-bit partial register.
// Ports   :
//   is_div    in   1        1 = divide step, 0 = multiply step
//   part_in   in   WIDTH+1  partial product (mult) / partial remainder (div)
//   low_in    in   WIDTH    multiplier bits (mult) / dividend-quotient bits (div)
//   opnd      in   WIDTH    multiplicand (mult) / divisor (div), magnitudes
//   part_out  out  WIDTH+1  partial register after this step
//   low_out   out  WIDTH    low register after this step
module mdu_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH:0]   part_in,
  input  logic [WIDTH-1:0] low_in,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH:0]   part_out,
  output logic [WIDTH-1:0] low_out
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] diff;

  always_comb begin
    // Multiply: add multiplicand when the multiplier LSB is set, then shift
    // the {part, low} pair right so product bits fall into low.
    sum    = part_in + (low_in[0] ? {1'b0, opnd} : '0);
    // Divide: shift the next dividend bit into the remainder, then try to
    // subtract. The extra top bit of diff is the borrow.
    rem_sh = {part_in[WIDTH-1:0], low_in[WIDTH-1]};
    diff   = {1'b0, rem_sh} - {2'b00, opnd};

    part_out = {1'b0, sum[WIDTH:1]};
    low_out  = {sum[0], low_in[WIDTH-1:1]};

    if (is_div) begin
      if (!diff[WIDTH+1]) begin
        part_out = diff[WIDTH:0];
        low_out  = {low_in[WIDTH-2:0], 1'b1};
      end else begin
        part_out = rem_sh;
        low_out  = {low_in[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative multiply/divide unit owning HI/LO
//
// Purpose : EX-stage MULT/MULTU/DIV/DIVU (one result bit per cycle) plus
//           MFHI/MFLO/MTHI/MTLO. Drives a combinational pipeline stall.
// Config  : MDU_DIV0_FLAG_EN - divide by zero skips iteration and raises div0.
// Ports   :
//   clk      in   1      rising-edge clock
//   reset    in   1      synchronous, active-high
//   op       in   4      MDU opcode (mdu_pkg OP_*), unused codes = NOP
//   a        in   WIDTH  rs: multiplicand / dividend / MTHI-MTLO data
//   b        in   WIDTH  rt: multiplier / divisor
//   kill     in   1      EX flush: abort in-flight op, ignore current op
//   stall    out  1      comb: valid op presented while busy and not killed
//   busy     out  1      FSM not idle
//   done     out  1      one-cycle pulse after HI/LO written by mult/div
//   div0     out  1      (MDU_DIV0_FLAG_EN only) pulses with done on x/0
//   hi, lo   out  WIDTH  architectural HI/LO
//   rd_data  out  WIDTH  comb: MFHI -> hi, MFLO -> lo, else 0
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             kill,
  output logic             stall,
  output logic             busy,
  output logic             done,
`ifdef MDU_DIV0_FLAG_EN
  output logic             div0,
`endif
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rd_data
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  mdu_state_t state, state_nxt;

  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   part;
  logic [WIDTH-1:0] low;
  logic [WIDTH-1:0] opnd;
  logic             is_div_q;
  logic             neg_q;    // negate product (mult) or quotient (div)
  logic             neg_r;    // negate remainder (signed div, negative dividend)

  logic [WIDTH:0]   step_part;
  logic [WIDTH-1:0] step_low;

  logic             op_signed;
  logic             op_div;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic             accept;
  logic             div0_hit;

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // ---------------------------------------------------------------- decode
  always_comb begin
    op_signed = (op == OP_MULT) || (op == OP_DIV);
    op_div    = (op == OP_DIV) || (op == OP_DIVU);
    a_neg     = op_signed & a[WIDTH-1];
    b_neg     = op_signed & b[WIDTH-1];
    // Two's complement of MIN_INT is itself, which is the correct unsigned
    // magnitude, so no special case is needed here.
    a_abs     = a_neg ? -a : a;
    b_abs     = b_neg ? -b : b;
    accept    = (state == ST_IDLE) && !kill && op_is_muldiv(op);
  end

`ifdef MDU_DIV0_FLAG_EN
  logic div0_pend;
  assign div0_hit = accept && op_div && (b == '0);
`else
  assign div0_hit = 1'b0;
`endif

  // ------------------------------------------------------------ step logic
  mdu_iter_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (is_div_q),
    .part_in  (part),
    .low_in   (low),
    .opnd     (opnd),
    .part_out (step_part),
    .low_out  (step_low)
  );

  // ------------------------------------------------------------------ FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != ST_IDLE);
    // kill already discards whatever op is presented, so it never stalls.
    stall     = busy && op_is_valid(op) && !kill;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = div0_hit ? ST_FIX : ST_RUN;
        end
      end
      ST_RUN: begin
        if (kill) begin
          state_nxt = ST_IDLE;
        end else if (cnt == LAST_STEP) begin
          state_nxt = ST_FIX;
        end
      end
      ST_FIX:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------ sign fixup
  always_comb begin
    prod     = {part[WIDTH-1:0], low};
    prod_fix = neg_q ? -prod : prod;
    quo_fix  = neg_q ? -low : low;
    rem_fix  = neg_r ? -part[WIDTH-1:0] : part[WIDTH-1:0];
  end

  // ------------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      part     <= '0;
      low      <= '0;
      opnd     <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
`ifdef MDU_DIV0_FLAG_EN
      div0_pend <= 1'b0;
      div0      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef MDU_DIV0_FLAG_EN
      div0 <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cnt      <= '0;
            is_div_q <= op_div;
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= op_div & a_neg;
            part     <= '0;
            // Divide shifts the dividend out of low; multiply shifts the
            // multiplier out of low and keeps the multiplicand in opnd.
            low      <= op_div ? a_abs : b_abs;
            opnd     <= op_div ? b_abs : a_abs;
`ifdef MDU_DIV0_FLAG_EN
            div0_pend <= div0_hit;
            if (div0_hit) begin
              // Preload the final answer so FIX writes it unchanged.
              part  <= {1'b0, a};
              low   <= '1;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
            end
`endif
          end else if (!kill && (op == OP_MTHI)) begin
            hi <= a;
          end else if (!kill && (op == OP_MTLO)) begin
            lo <= a;
          end
        end
        ST_RUN: begin
          if (!kill) begin
            part <= step_part;
            low  <= step_low;
            cnt  <= cnt + CW'(1);
          end
        end
        ST_FIX: begin
          if (!kill) begin
            if (is_div_q) begin
              hi <= rem_fix;
              lo <= quo_fix;
            end else begin
              {hi, lo} <= prod_fix;
            end
            done <= 1'b1;
`ifdef MDU_DIV0_FLAG_EN
            div0 <= div0_pend;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------- read port
  always_comb begin
    rd_data = '0;
    if (op == OP_MFHI) begin
      rd_data = hi;
    end else if (op == OP_MFLO) begin
      rd_data = lo;
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - directed vector bench for mdu_iter
module tb_mdu_iter;
  import mdu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         kill;
  logic         stall;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic [W-1:0] rd_data;
`ifdef MDU_DIV0_FLAG_EN
  logic         div0;
`endif

  mdu_iter #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .op      (op),
    .a       (a),
    .b       (b),
    .kill    (kill),
    .stall   (stall),
    .busy    (busy),
    .done    (done),
`ifdef MDU_DIV0_FLAG_EN
    .div0    (div0),
`endif
    .hi      (hi),
    .lo      (lo),
    .rd_data (rd_data)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic div0_at_done;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Presents a mult/div op for one cycle; returns the cycle (counted from the
  // presentation cycle) in which done is seen, and how many cycles busy was high.
  task automatic run_md(input logic [3:0] o, input logic [31:0] va, input logic [31:0] vb,
                        output int lat, output int busy_cyc);
    @(negedge clk);
    op = o; a = va; b = vb;
    lat = -1;
    busy_cyc = 0;
    div0_at_done = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == 1) op = OP_NOP;
      if (busy) busy_cyc++;
      if (done) begin
        lat = k;
`ifdef MDU_DIV0_FLAG_EN
        div0_at_done = div0;
`endif
        break;
      end
    end
  endtask

  task automatic write_reg(input logic [3:0] o, input logic [31:0] v);
    @(negedge clk);
    op = o; a = v;
    @(negedge clk);
    op = OP_NOP;
  endtask

  int  lat;
  int  bcyc;
  int  n;
  logic saw_done;

  initial begin
    vecs[0]  = '{OP_MULT,  32'd7,          32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1]  = '{OP_MULTU, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2]  = '{OP_DIVU,  32'd100,        32'd7,        32'd2,        32'd14};
    vecs[3]  = '{OP_DIV,   32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4]  = '{OP_DIV,   32'h80000000,   32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5]  = '{OP_MULT,  32'hFFFFFFFB,   32'hFFFFFFFA, 32'h00000000, 32'h0000001E};
    vecs[6]  = '{OP_MULTU, 32'h00010000,   32'h00010000, 32'h00000001, 32'h00000000};
    vecs[7]  = '{OP_DIV,   32'd7,          32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[8]  = '{OP_DIVU,  32'hFFFFFFFF,   32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
    vecs[9]  = '{OP_MULT,  32'h80000000,   32'h80000000, 32'h40000000, 32'h00000000};
    vecs[10] = '{OP_DIV,   32'hFFFFFFF8,   32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002};

    reset = 1'b1; kill = 1'b0; op = OP_NOP; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset_busy",  {31'd0, busy},  32'd0);
    check("reset_done",  {31'd0, done},  32'd0);
    check("reset_stall", {31'd0, stall}, 32'd0);
    check("reset_hi",    hi, 32'd0);
    check("reset_lo",    lo, 32'd0);
    reset = 1'b0;

    // Table of multiply/divide vectors.
    for (int i = 0; i < 11; i++) begin
      run_md(vecs[i].op, vecs[i].a, vecs[i].b, lat, bcyc);
      check($sformatf("vec%0d_latency", i), lat,  32'd34);
      check($sformatf("vec%0d_busy", i),    bcyc, 32'd33);
      check($sformatf("vec%0d_hi", i),      hi,   vecs[i].hi);
      check($sformatf("vec%0d_lo", i),      lo,   vecs[i].lo);
`ifdef MDU_DIV0_FLAG_EN
      check($sformatf("vec%0d_div0", i), {31'd0, div0_at_done}, 32'd0);
`endif
      @(negedge clk);
      check($sformatf("vec%0d_done_pulse", i), {31'd0, done}, 32'd0);
    end

    // Divide by zero.
    run_md(OP_DIVU, 32'd9, 32'd0, lat, bcyc);
`ifdef MDU_DIV0_FLAG_EN
    check("divu0_latency", lat,  32'd2);
    check("divu0_busy",    bcyc, 32'd1);
    check("divu0_flag",    {31'd0, div0_at_done}, 32'd1);
`else
    check("divu0_latency", lat,  32'd34);
    check("divu0_busy",    bcyc, 32'd33);
`endif
    check("divu0_hi", hi, 32'd9);
    check("divu0_lo", lo, 32'hFFFFFFFF);
    run_md(OP_DIV, 32'hFFFFFFF7, 32'd0, lat, bcyc);
    check("div0s_hi", hi, 32'hFFFFFFF7);
`ifdef MDU_DIV0_FLAG_EN
    check("div0s_lo", lo, 32'hFFFFFFFF);
`else
    check("div0s_lo", lo, 32'h00000001);
`endif

    // MTHI/MTLO then MFHI/MFLO in idle.
    write_reg(OP_MTHI, 32'h12345678);
    write_reg(OP_MTLO, 32'h9ABCDEF0);
    @(negedge clk);
    op = OP_MFHI;
    #1 check("mfhi_rd", rd_data, 32'h12345678);
    check("mfhi_stall", {31'd0, stall}, 32'd0);
    op = OP_MFLO;
    #1 check("mflo_rd", rd_data, 32'h9ABCDEF0);
    op = OP_NOP;
    #1 check("nop_rd", rd_data, 32'd0);

    // MULT then MFLO five cycles later: stalls until FIX completes.
    @(negedge clk);
    op = OP_MULT; a = 32'd3; b = 32'd4;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      op = (k == 5) ? OP_MFLO : OP_NOP;
    end
    #1 check("mflo_stall_start", {31'd0, stall}, 32'd1);
    n = -1;
    for (int k = 5; k <= 100; k++) begin
      if (k > 5) begin
        @(negedge clk);
        #1;
      end
      if (!stall) begin
        n = k;
        break;
      end
    end
    check("mflo_stall_release", n, 32'd34);
    check("mflo_new_lo", rd_data, 32'd12);
    op = OP_NOP;

    // Kill in the middle of a divide.
    write_reg(OP_MTHI, 32'h0000AAAA);
    write_reg(OP_MTLO, 32'h0000BBBB);
    @(negedge clk);
    op = OP_DIV; a = 32'd100; b = 32'd3;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      op = OP_NOP;
    end
    kill = 1'b1; op = OP_MFLO;
    #1 check("kill_busy_before", {31'd0, busy},  32'd1);
    check("kill_stall_masked",   {31'd0, stall}, 32'd0);
    @(negedge clk);
    kill = 1'b0; op = OP_NOP;
    check("kill_busy_after", {31'd0, busy}, 32'd0);
    check("kill_hi", hi, 32'h0000AAAA);
    check("kill_lo", lo, 32'h0000BBBB);
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("kill_no_done", {31'd0, saw_done}, 32'd0);

    // Ops presented together with kill in idle are ignored.
    @(negedge clk);
    op = OP_MTHI; a = 32'h77; kill = 1'b1;
    #1 check("kill_idle_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    op = OP_MULT; a = 32'd2; b = 32'd2;
    @(negedge clk);
    kill = 1'b0; op = OP_NOP;
    check("kill_idle_hi",   hi, 32'h0000AAAA);
    check("kill_idle_busy", {31'd0, busy}, 32'd0);

    // Unused opcode behaves as NOP.
    @(negedge clk);
    op = 4'hF; a = 32'h99;
    #1 check("unused_rd", rd_data, 32'd0);
    @(negedge clk);
    op = OP_NOP;
    check("unused_busy", {31'd0, busy}, 32'd0);
    check("unused_hi",   hi, 32'h0000AAAA);
    check("unused_lo",   lo, 32'h0000BBBB);

    // Reset in the middle of a multiply.
    @(negedge clk);
    op = OP_MULT; a = 32'd5; b = 32'd6;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      op = OP_NOP;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_hi",   hi, 32'd0);
    check("midreset_lo",   lo, 32'd0);
    write_reg(OP_MTHI, 32'h55);
    op = OP_MFHI;
    #1 check("midreset_mfhi", rd_data, 32'h55);
    op = OP_NOP;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
